axis_hdr_insert_varlen: RTL and testbench
=========================================

// Module: axis_hdr_insert_varlen
// PURPOSE
//  Second-generation AXI-Stream header inserter. Prepends a per-packet header of
//  0..HDR_MAX_BYTES bytes, which can span several output beats, to a payload packet.
//  The merged byte stream is repacked so every output beat except the last is full.
//  Sits between packet producers and the framing/MAC stage. hdr_len=0 gives a per-packet bypass.
// PARAMETERS
//  DATA_WD       32              payload/output data width, multiple of 8
//  DATA_BYTE_WD  DATA_WD/8       bytes per beat (W below)
//  HDR_MAX_BYTES 2*DATA_BYTE_WD  max header bytes per packet, >=1
//  LEN_WD        $clog2(HDR_MAX_BYTES+1)  width of s_hdr_len
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  asynchronous, active-high reset
//  s_hdr_tvalid   in   1                  header descriptor valid
//  s_hdr_tdata    in   8*HDR_MAX_BYTES    header bytes; byte0 = MSB byte
//  s_hdr_len      in   LEN_WD             header byte count (0 = bypass)
//  s_hdr_tready   out  1                  header accepted
//  s_axis_tvalid  in   1                  payload valid
//  s_axis_tdata   in   DATA_WD            payload; byte0 = MSB byte
//  s_axis_tkeep   in   DATA_BYTE_WD       MSB-contiguous; all ones unless tlast
//  s_axis_tlast   in   1                  last payload beat
//  s_axis_tready  out  1                  payload accepted
//  m_axis_tvalid  out  1                  output valid (registered)
//  m_axis_tdata   out  DATA_WD            output data (registered)
//  m_axis_tkeep   out  DATA_BYTE_WD       all ones except on tlast beat (MSB-contiguous)
//  m_axis_tlast   out  1                  last output beat of packet
//  m_axis_tready  in   1                  downstream ready
//  pkt_done       out  1                  1-cycle pulse on output tlast handshake
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: m_axis_tvalid/tdata/tkeep/tlast, both treadys, pkt_done.
//   Async assert mid-packet clears state immediately and drops the partial packet.
//  adv = !m_axis_tvalid || m_axis_tready. Output regs load only when adv=1.
//   Stalled outputs hold all fields stable.
//  FSM IDLE: s_hdr_tready=1, s_axis_tready=0. On header handshake:
//   - Load hdr buffer with h = min(s_hdr_len, HDR_MAX_BYTES) bytes.
//   - Go to HDR if h>=W. Otherwise go to BODY with residue r=h bytes.
//  HDR: s_hdr_tready=0, s_axis_tready=0. On adv:
//   - Emit next W header bytes (keep all ones, tlast=0); h-=W.
//   - When h<W, go to BODY with r=h.
//  BODY: s_axis_tready=adv (combinational path from m_axis_tready).
//   On payload handshake with k=popcount(tkeep) bytes:
//   - Beat = r residue bytes followed by payload bytes.
//   - not tlast: emit W bytes, r=r+k-W (0..W-1), stay in BODY.
//   - tlast, r+k<=W: emit r+k bytes, keep MSB-contiguous, tlast=1 -> IDLE.
//   - tlast, r+k>W: emit W bytes (tlast=0), r=r+k-W -> FLUSH.
//  FLUSH: both treadys 0. On adv emit r bytes with tlast=1 -> IDLE.
//  Latency: first output beat is valid the cycle after the header handshake
//   (HDR, or BODY once payload arrives).
//  Throughput: 1 beat/cycle in HDR/BODY with no bubbles. 1 idle cycle per packet in IDLE.
//  Next header is not accepted until the current packet's tlast has been loaded into the output reg.
//  Payload waiting before its header is held off (tready=0); no data loss.
//  Non-contiguous or non-full non-last tkeep is a protocol violation; output is undefined.
//  pkt_done=1 in the cycle m_axis_tvalid&m_axis_tready&m_axis_tlast.
// TESTING (W=4, HDR_MAX_BYTES=8)
//  1 hdr len3 AABBCC, payload 00010203,04050607(last,1111)
//    -> AABBCC00/1111, 01020304/1111, 050607xx/1110 last.
//  2 hdr len0, payload 11223344,5566xxxx(1100 last)
//    -> identical beats/keeps, first out 1 cycle after payload accept.
//  3 hdr len8 A0..A7, payload 99xxxxxx(1000 last)
//    -> A0A1A2A3, A4A5A6A7, 99xxxxxx/1000 last; len9 clamps to 8.
//  4 hdr len2 C0C1, payload 10111213, 20212223(1110 last)
//    -> C0C11011, 12132021, 22xxxxxx/1000 last (FLUSH beat).
//  5 200 random packets, random lens, 50% random m_axis_tready, payload valid gaps
//    -> byte stream matches model; fields stable while stalled; pkt_done count=200.
//  6 rst asserted mid-BODY
//    -> all outputs 0 same cycle; next packet (case 1) output exact.

Source files
------------

// File: rtl/axis_hdr_insert_varlen_if.sv
// AXI-Stream beat bundle (data, MSB-first keep, last) with producer/consumer views.
interface axis_hdr_insert_varlen_if #(
  parameter int unsigned DATA_WD = 32
);
  localparam int unsigned KEEP_WD = DATA_WD / 8;

  logic               tvalid;
  logic [DATA_WD-1:0] tdata;
  logic [KEEP_WD-1:0] tkeep;
  logic               tlast;
  logic               tready;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_hdr_insert_varlen.sv
// Prepends a variable-length header to each payload packet and repacks the merged
// byte stream so that every output beat except the last one is full.
module axis_hdr_insert_varlen #(
  parameter int unsigned DATA_WD       = 32,
  parameter int unsigned DATA_BYTE_WD  = DATA_WD / 8,
  parameter int unsigned HDR_MAX_BYTES = 2 * DATA_BYTE_WD,
  parameter int unsigned LEN_WD        = $clog2(HDR_MAX_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_hdr_tvalid,
  input  logic [8*HDR_MAX_BYTES-1:0] s_hdr_tdata,
  input  logic [LEN_WD-1:0]          s_hdr_len,
  output logic                       s_hdr_tready,
  axis_hdr_insert_varlen_if.slave    s_axis,
  axis_hdr_insert_varlen_if.master   m_axis,
  output logic                       pkt_done
);

  localparam int unsigned W         = DATA_BYTE_WD;
  localparam int unsigned BUF_BYTES = (HDR_MAX_BYTES > W) ? HDR_MAX_BYTES : W;
  localparam int unsigned BUF_WD    = 8 * BUF_BYTES;
  localparam int unsigned HDR_WD    = 8 * HDR_MAX_BYTES;
  localparam int unsigned CNT_WD    = $clog2(BUF_BYTES + 1);
  localparam int unsigned TOT_WD    = $clog2(2 * W + 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [BUF_WD-1:0]   buf_q, buf_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                hdr_rdy_q, hdr_rdy_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_WD-1:0]  m_data_q, m_data_d;
  logic [W-1:0]        m_keep_q, m_keep_d;
  logic                m_last_q, m_last_d;

  logic                adv, hdr_hs, s_tready_c, pay_hs;
  int unsigned         hlen;
  logic [HDR_WD-1:0]   hdr_m;
  logic [BUF_WD-1:0]   hdr_buf;
  logic [TOT_WD-1:0]   kcnt, tot;
  logic [DATA_WD-1:0]  pay_m;
  logic [2*DATA_WD-1:0] merged;
  logic [BUF_WD-1:0]   res_next;

  // MSB-contiguous keep with n bytes set
  function automatic logic [W-1:0] keep_of(input logic [TOT_WD-1:0] n);
    logic [W-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (32'(n) > i) k[W-1-i] = 1'b1;
    end
    return k;
  endfunction

  assign adv        = !m_valid_q || m_axis.tready;
  assign hdr_hs     = hdr_rdy_q && s_hdr_tvalid;
  assign s_tready_c = (state_q == BODY) && adv;
  assign pay_hs     = s_tready_c && s_axis.tvalid;

  // Header clamp/mask and residue+payload byte merge
  always_comb begin
    hlen    = 32'(s_hdr_len);
    hdr_m   = '0;
    kcnt    = '0;
    pay_m   = '0;
    if (hlen > HDR_MAX_BYTES) hlen = HDR_MAX_BYTES;
    for (int unsigned i = 0; i < HDR_MAX_BYTES; i++) begin
      if (i < hlen) hdr_m[8*(HDR_MAX_BYTES-1-i) +: 8] = s_hdr_tdata[8*(HDR_MAX_BYTES-1-i) +: 8];
    end
    hdr_buf = BUF_WD'(hdr_m) << (BUF_WD - HDR_WD);
    // Dropping unkept lanes keeps the byte after the last valid one at zero
    for (int unsigned i = 0; i < W; i++) begin
      kcnt = kcnt + TOT_WD'(s_axis.tkeep[i]);
      pay_m[8*i +: 8] = s_axis.tdata[8*i +: 8] & {8{s_axis.tkeep[i]}};
    end
    tot      = TOT_WD'(cnt_q) + kcnt;
    merged   = {buf_q[BUF_WD-1 -: DATA_WD], {DATA_WD{1'b0}}}
             | ({pay_m, {DATA_WD{1'b0}}} >> {cnt_q, 3'b000});
    res_next = BUF_WD'(merged[DATA_WD-1:0]) << (BUF_WD - DATA_WD);
  end

  // Next-state and output-register loads
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (adv) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hdr_hs) begin
          buf_d   = hdr_buf;
          cnt_d   = CNT_WD'(hlen);
          state_d = (hlen >= W) ? HDR : BODY;
        end
      end
      HDR: begin
        if (adv) begin
          m_valid_d = 1'b1;
          m_data_d  = buf_q[BUF_WD-1 -: DATA_WD];
          m_keep_d  = '1;
          m_last_d  = 1'b0;
          buf_d     = buf_q << DATA_WD;
          cnt_d     = cnt_q - CNT_WD'(W);
          if (32'(cnt_d) < W) state_d = BODY;
        end
      end
      BODY: begin
        if (pay_hs) begin
          m_valid_d = 1'b1;
          m_data_d  = merged[2*DATA_WD-1 -: DATA_WD];
          if (s_axis.tlast && (tot <= TOT_WD'(W))) begin
            m_keep_d = keep_of(tot);
            m_last_d = 1'b1;
            buf_d    = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            m_keep_d = '1;
            m_last_d = 1'b0;
            buf_d    = res_next;
            cnt_d    = CNT_WD'(tot - TOT_WD'(W));
            if (s_axis.tlast) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          m_valid_d = 1'b1;
          m_data_d  = buf_q[BUF_WD-1 -: DATA_WD];
          m_keep_d  = keep_of(TOT_WD'(cnt_q));
          m_last_d  = 1'b1;
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hdr_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      hdr_rdy_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      hdr_rdy_q <= hdr_rdy_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_hdr_tready  = hdr_rdy_q;
  assign s_axis.tready = s_tready_c;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tlast  = m_last_q;
  assign pkt_done      = m_valid_q && m_axis.tready && m_last_q;

endmodule

// File: tb/tb_axis_hdr_insert_varlen.sv
// Bench for axis_hdr_insert_varlen: byte-stream reference model plus literal beat checks.
module tb_axis_hdr_insert_varlen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_tvalid = 1'b0;
  logic [63:0] hdr_tdata = '0;
  logic [3:0]  hdr_len = '0;
  logic        hdr_tready;
  logic        pkt_done;

  axis_hdr_insert_varlen_if #(.DATA_WD(32)) s_if ();
  axis_hdr_insert_varlen_if #(.DATA_WD(32)) m_if ();

  axis_hdr_insert_varlen #(.DATA_WD(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_hdr_tvalid (hdr_tvalid),
    .s_hdr_tdata  (hdr_tdata),
    .s_hdr_len    (hdr_len),
    .s_hdr_tready (hdr_tready),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .pkt_done     (pkt_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pd_cnt = 0;
  logic mon_en = 1'b0;
  logic rdy_rand = 1'b0;

  // Packet descriptors shared by the drivers
  logic [3:0]  p_len [256];
  logic [63:0] p_hdr [256];
  int          p_plen [256];
  logic [7:0]  p_pay [256][16];

  // Reference model: expected merged byte stream and per-packet byte totals
  logic [7:0]  exp_q [$];
  int          len_q [$];
  logic [31:0] cap_d [$];
  logic [3:0]  cap_k [$];
  logic        cap_l [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] kof(input int n);
    logic [3:0] k = '0;
    for (int i = 0; i < 4; i++) if (i < n) k[3-i] = 1'b1;
    return k;
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m = '0;
    for (int j = 0; j < 4; j++) m[31-8*j -: 8] = {8{k[3-j]}};
    return m;
  endfunction

  task automatic push_exp(input int i);
    int h = (int'(p_len[i]) > 8) ? 8 : int'(p_len[i]);
    logic [63:0] hv = p_hdr[i];
    for (int b = 0; b < h; b++) exp_q.push_back(hv[63-8*b -: 8]);
    for (int b = 0; b < p_plen[i]; b++) exp_q.push_back(p_pay[i][b]);
    len_q.push_back(h + p_plen[i]);
  endtask

  task automatic drive_hdrs(input int n, input int gap);
    int wc;
    logic ok;
    for (int i = 0; i < n; i++) begin
      repeat ((gap > 0) ? $urandom_range(0, gap) : 0) begin @(posedge clk); #1; end
      hdr_tvalid = 1'b1;
      hdr_tdata  = p_hdr[i];
      hdr_len    = p_len[i];
      wc = 0;
      do begin @(negedge clk); ok = hdr_tready; wc++; end while (!ok && wc < 4000);
      if (!ok) chk("hdr_accept_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      hdr_tvalid = 1'b0;
      hdr_tdata  = {$urandom, $urandom};
    end
  endtask

  task automatic drive_pays(input int n, input int gap);
    int wc, nb, idx;
    logic ok;
    logic [31:0] d;
    logic [3:0] k;
    for (int i = 0; i < n; i++) begin
      nb = (p_plen[i] + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        repeat ((gap > 0) ? $urandom_range(0, gap) : 0) begin @(posedge clk); #1; end
        for (int j = 0; j < 4; j++) begin
          idx = b * 4 + j;
          if (idx < p_plen[i]) begin d[31-8*j -: 8] = p_pay[i][idx]; k[3-j] = 1'b1; end
          else begin d[31-8*j -: 8] = 8'($urandom); k[3-j] = 1'b0; end
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = (b == nb - 1);
        wc = 0;
        do begin @(negedge clk); ok = s_if.tready; wc++; end while (!ok && wc < 4000);
        if (!ok) chk("pay_accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (len_q.size() != 0 && c < 20000) begin @(posedge clk); c++; end
    #1;
    chk("drain_pending_packets", 64'(len_q.size()), 64'd0);
  endtask

  task automatic run_one(input logic [3:0] len, input logic [63:0] hdr, input int plen,
                         input logic [63:0] pay);
    p_len[0] = len; p_hdr[0] = hdr; p_plen[0] = plen;
    for (int b = 0; b < 8; b++) p_pay[0][b] = pay[63-8*b -: 8];
    cap_d.delete(); cap_k.delete(); cap_l.delete();
    push_exp(0);
    fork
      drive_hdrs(1, 0);
      drive_pays(1, 0);
    join
    wait_drain();
  endtask

  task automatic chk_cap(input string nm, input int i, input logic [31:0] d,
                         input logic [3:0] k, input logic l);
    if (i >= cap_d.size()) begin
      n_cmp++; n_err++;
      $display("FAIL %s: beat %0d missing, required %h/%b", nm, i, d, k);
    end else chk(nm, {cap_d[i], cap_k[i], cap_l[i]}, {d, k, l});
  endtask

  always begin
    @(posedge clk); #1;
    m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every output handshake is checked against the model
  initial begin : mon
    logic stall;
    logic [37:0] snap, cur;
    int rem, cnt;
    logic [3:0] ek;
    logic [31:0] em, ed;
    stall = 1'b0;
    snap  = '0;
    forever begin
      @(negedge clk);
      cur = {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast};
      if (!mon_en) stall = 1'b0;
      else begin
        if (stall) chk("stall_hold", 64'(cur), 64'(snap));
        chk("pkt_done_pulse", 64'(pkt_done), 64'(m_if.tvalid & m_if.tready & m_if.tlast));
        if (pkt_done) pd_cnt++;
        if (m_if.tvalid && m_if.tready) begin
          if (len_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_beat: got %h, required no beat", m_if.tdata);
          end else begin
            rem = len_q[0];
            cnt = (rem < 4) ? rem : 4;
            ek  = kof(cnt);
            em  = kmask(ek);
            ed  = '0;
            for (int j = 0; j < cnt; j++) ed[31-8*j -: 8] = exp_q.pop_front();
            chk("beat_keep", 64'(m_if.tkeep), 64'(ek));
            chk("beat_last", 64'(m_if.tlast), 64'(rem <= 4));
            chk("beat_data", 64'(m_if.tdata & em), 64'(ed));
            cap_d.push_back(m_if.tdata & em);
            cap_k.push_back(m_if.tkeep);
            cap_l.push_back(m_if.tlast);
            rem -= cnt;
            if (rem == 0) void'(len_q.pop_front());
            else len_q[0] = rem;
          end
        end
        stall = m_if.tvalid && !m_if.tready;
        snap  = cur;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pd0, wc;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    #3;
    chk("reset_outputs",
        {26'd0, hdr_tready, s_if.tready, m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, pkt_done},
        64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;

    // Case 1: 3-byte header shifts payload across beats
    run_one(4'd3, 64'hAABBCC00_00000000, 8, 64'h00010203_04050607);
    chk("t1_beats", 64'(cap_d.size()), 64'd3);
    chk_cap("t1_b0", 0, 32'hAABBCC00, 4'b1111, 1'b0);
    chk_cap("t1_b1", 1, 32'h01020304, 4'b1111, 1'b0);
    chk_cap("t1_b2", 2, 32'h05060700, 4'b1110, 1'b1);

    // Case 2: bypass
    run_one(4'd0, 64'hDEADBEEF_DEADBEEF, 6, 64'h11223344_55660000);
    chk("t2_beats", 64'(cap_d.size()), 64'd2);
    chk_cap("t2_b0", 0, 32'h11223344, 4'b1111, 1'b0);
    chk_cap("t2_b1", 1, 32'h55660000, 4'b1100, 1'b1);

    // Case 3: full-length header, then over-length header clamped
    run_one(4'd8, 64'hA0A1A2A3_A4A5A6A7, 1, 64'h99000000_00000000);
    chk_cap("t3_b0", 0, 32'hA0A1A2A3, 4'b1111, 1'b0);
    chk_cap("t3_b1", 1, 32'hA4A5A6A7, 4'b1111, 1'b0);
    chk_cap("t3_b2", 2, 32'h99000000, 4'b1000, 1'b1);
    run_one(4'd9, 64'hA0A1A2A3_A4A5A6A7, 1, 64'h99000000_00000000);
    chk("t3c_beats", 64'(cap_d.size()), 64'd3);
    chk_cap("t3c_b1", 1, 32'hA4A5A6A7, 4'b1111, 1'b0);
    chk_cap("t3c_b2", 2, 32'h99000000, 4'b1000, 1'b1);

    // Case 4: residue spills into a trailing flush beat
    run_one(4'd2, 64'hC0C10000_00000000, 7, 64'h10111213_20212200);
    chk_cap("t4_b0", 0, 32'hC0C11011, 4'b1111, 1'b0);
    chk_cap("t4_b1", 1, 32'h12132021, 4'b1111, 1'b0);
    chk_cap("t4_b2", 2, 32'h22000000, 4'b1000, 1'b1);

    // Case 5: random packets, random backpressure and source gaps
    for (int i = 0; i < 200; i++) begin
      p_len[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      p_hdr[i]  = {$urandom, $urandom};
      p_plen[i] = $urandom_range(1, 16);
      for (int b = 0; b < 16; b++) p_pay[i][b] = 8'($urandom);
      push_exp(i);
    end
    pd0 = pd_cnt;
    rdy_rand = 1'b1;
    fork
      drive_hdrs(200, 3);
      drive_pays(200, 2);
    join
    wait_drain();
    chk("random_pkt_done_count", 64'(pd_cnt - pd0), 64'd200);
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Case 6: asynchronous reset in the middle of a packet body
    mon_en = 1'b0;
    hdr_tvalid = 1'b1; hdr_tdata = 64'hAABBCC00_00000000; hdr_len = 4'd3;
    wc = 0;
    do begin @(negedge clk); wc++; end while (!hdr_tready && wc < 100);
    chk("t6_hdr_accept", 64'(hdr_tready), 64'd1);
    @(posedge clk); #1;
    hdr_tvalid = 1'b0;
    s_if.tvalid = 1'b1; s_if.tdata = 32'h00010203; s_if.tkeep = 4'hF; s_if.tlast = 1'b0;
    wc = 0;
    do begin @(negedge clk); wc++; end while (!s_if.tready && wc < 100);
    chk("t6_pay_accept", 64'(s_if.tready), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    chk("t6_reset_outputs",
        {26'd0, hdr_tready, s_if.tready, m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, pkt_done},
        64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); len_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_one(4'd3, 64'hAABBCC00_00000000, 8, 64'h00010203_04050607);
    chk("t6_beats", 64'(cap_d.size()), 64'd3);
    chk_cap("t6_b0", 0, 32'hAABBCC00, 4'b1111, 1'b0);
    chk_cap("t6_b1", 1, 32'h01020304, 4'b1111, 1'b0);
    chk_cap("t6_b2", 2, 32'h05060700, 4'b1110, 1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
